// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: RGB565 test-pattern source for a 480x272-class LCD.
// It sits behind a timing generator: it delays DE/HSYNC/VSYNC by one
// pixel-enable cycle and produces the pixel colour aligned with the delayed DE.
// There are four patterns: colour bars, gradient, checkerboard and border.
// In auto mode the pattern advances every FRAMES_PER_PAT frames.
module lcd_pattern_gen #(
    parameter int H_ACTIVE       = 480,
    parameter int V_ACTIVE       = 272,
    parameter int FRAMES_PER_PAT = 60
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       PIX_CE,
    input  logic       IN_DE,
    input  logic       IN_HSYNC,
    input  logic       IN_VSYNC,
    input  logic [1:0] PAT_SEL,
    input  logic       AUTO,
    output logic       OUT_DE,
    output logic       OUT_HSYNC,
    output logic       OUT_VSYNC,
    output logic [4:0] OUT_R,
    output logic [5:0] OUT_G,
    output logic [4:0] OUT_B,
    output logic [1:0] PAT_CUR
);

    localparam logic [8:0] X_MAX = 9'(H_ACTIVE - 1);
    localparam logic [8:0] Y_MAX = 9'(V_ACTIVE - 1);
    localparam logic [7:0] F_MAX = 8'(FRAMES_PER_PAT - 1);
    localparam int         BAR_W = H_ACTIVE / 8;

    // Increment that sticks at the given limit instead of wrapping.
    function automatic logic [8:0] sat_inc9(input logic [8:0] v, input logic [8:0] lim);
        return (v >= lim) ? lim : v + 9'd1;
    endfunction

    // The delayed sync/DE registers also serve as the edge detectors
    // (de_q is the previous DE and vs_q is the previous VSYNC).
    logic       de_q, hs_q, vs_q;
    logic [4:0] r_q, r_d;
    logic [5:0] g_q, g_d;
    logic [4:0] b_q, b_d;
    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [7:0] fc_q, fc_d;
    logic [1:0] pat_q, pat_d;
    logic [2:0] bar;
    logic       de_fall, frame_edge;

    assign de_fall    = de_q & ~IN_DE;
    assign frame_edge = vs_q & ~IN_VSYNC;

    // Counter and pattern-register next state. A frame boundary clear beats a line increment.
    always_comb begin
        x_d   = IN_DE ? sat_inc9(x_q, X_MAX) : 9'd0;
        y_d   = y_q;
        fc_d  = fc_q;
        pat_d = pat_q;
        if (frame_edge) begin
            y_d  = 9'd0;
            fc_d = (fc_q >= F_MAX) ? 8'd0 : fc_q + 8'd1;
            if (AUTO) begin
                if (fc_q >= F_MAX) pat_d = pat_q + 2'd1;
            end else begin
                pat_d = PAT_SEL;
            end
        end else if (de_fall) begin
            y_d = sat_inc9(y_q, Y_MAX);
        end
    end

    // Pixel colour from the pre-increment x/y, blanked to black outside active video.
    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(x_q) >= i * BAR_W) bar = 3'(i);
        end
        r_d = 5'd0;
        g_d = 6'd0;
        b_d = 5'd0;
        case (pat_q)
            2'd0: begin
                // White, yellow, cyan, green, magenta, red, blue, black: each
                // primary is a single inverted bit of the bar index.
                r_d = {5{~bar[1]}};
                g_d = {6{~bar[2]}};
                b_d = {5{~bar[0]}};
            end
            2'd1: begin
                r_d = x_q[8:4];
                g_d = y_q[8:3];
                b_d = fc_q[4:0];
            end
            2'd2: begin
                if (x_q[4] ^ y_q[4]) begin
                    r_d = 5'd31;
                    g_d = 6'd63;
                    b_d = 5'd31;
                end
            end
            default: begin
                b_d = 5'd31;
                if (x_q == 9'd0 || x_q == X_MAX || y_q == 9'd0 || y_q == Y_MAX) begin
                    r_d = 5'd31;
                    g_d = 6'd63;
                end
            end
        endcase
        if (!IN_DE) begin
            r_d = 5'd0;
            g_d = 6'd0;
            b_d = 5'd0;
        end
    end

    // All state advances only on pixel-enable edges. Reset drives the outputs to their idle levels.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            r_q   <= 5'd0;
            g_q   <= 6'd0;
            b_q   <= 5'd0;
            x_q   <= 9'd0;
            y_q   <= 9'd0;
            fc_q  <= 8'd0;
            pat_q <= 2'd0;
        end else if (PIX_CE) begin
            de_q  <= IN_DE;
            hs_q  <= IN_HSYNC;
            vs_q  <= IN_VSYNC;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            pat_q <= pat_d;
        end
    end

    assign OUT_DE    = de_q;
    assign OUT_HSYNC = hs_q;
    assign OUT_VSYNC = vs_q;
    assign OUT_R     = r_q;
    assign OUT_G     = g_q;
    assign OUT_B     = b_q;
    assign PAT_CUR   = pat_q;

endmodule
